text_cell_renderer: RTL and testbench
=====================================

Name: text_cell_renderer

Overview:
- Character-cell text renderer. It holds a COLS x ROWS text buffer of 7-bit ASCII codes.
- It is driven by the VGA timing generator's pixel coordinates. It reads the font ROM through that ROM's char_code/row_addr/row_data interface and serialises each 8-bit glyph row into a 1-bit pixel stream for the colour mixer.
- Each cell is 8x16 pixels, MSB = leftmost pixel. It supports a blinking inverse-video cursor.

Parameters:
- COLS, 80, text columns.
- ROWS, 30, text rows.
- ORIGIN_X, 0, left pixel of the text window.
- ORIGIN_Y, 0, top pixel of the text window.
- BLINK_FRAMES, 30, frame_start pulses per cursor blink phase.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high reset.
- pixel_x  in  10  current pixel column.
- pixel_y  in  10  current pixel row.
- de  in  1  display enable for this pixel.
- frame_start  in  1  one-cycle pulse per frame.
- wr_en  in  1  text buffer write strobe.
- wr_col  in  7  write column.
- wr_row  in  5  write row.
- wr_char  in  7  ASCII code to store.
- cursor_en  in  1  cursor display enable.
- cursor_col  in  7  cursor column.
- cursor_row  in  5  cursor row.
- font_char_code  out  7  to font ROM char_code.
- font_row_addr  out  4  to font ROM row_addr.
- font_row_data  in  8  from font ROM row_data (combinational ROM).
- pix_on  out  1  1 = foreground pixel.
- pix_valid  out  1  delayed de, aligned with pix_on.
- busy  out  1  high while the buffer clear sweep runs.

Behaviour:
- Reset (async, active-high):
  - pix_on=0, pix_valid=0, busy=1.
  - font_char_code=7'h20, font_row_addr=0.
  - Blink counter=0, blink phase=0, clear counter=0.
- Clear sweep:
  - Starts on reset release.
  - Writes 7'h20 (space) to addresses 0..COLS*ROWS-1, one per cycle.
  - busy deasserts on the cycle after address COLS*ROWS-1 is written, i.e. 2400 cycles for the defaults.
  - While busy: wr_en is ignored, pix_on=0, pix_valid follows de normally.
  - Reset asserted mid-sweep restarts the sweep from 0.
- Buffer:
  - Address = row*COLS + col.
  - Writes are synchronous.
  - Writes with wr_col>=COLS or wr_row>=ROWS are ignored.
  - Reads are synchronous and read-first: a same-cycle write to the address being read returns the old code.
- Pipeline, fixed latency 2: the pixel presented before edge N appears on pix_on/pix_valid after edge N+2.
  - S0 (edge N):
    - lx=pixel_x-ORIGIN_X, ly=pixel_y-ORIGIN_Y.
    - in_win = de & pixel_x>=ORIGIN_X & lx<COLS*8 & pixel_y>=ORIGIN_Y & ly<ROWS*16.
    - Issue buffer read at (ly>>4)*COLS+(lx>>3).
    - Register lx[2:0], ly[3:0], in_win, de, and cursor_hit = cursor_en & (lx>>3)==cursor_col & (ly>>4)==cursor_row.
  - S1 (edge N+1):
    - font_char_code = buffer read data; font_row_addr = registered ly[3:0]. Both driven from registers.
    - Font ROM output is combinational into S2.
  - S2 (edge N+2):
    - bit = font_row_data[7-lx[2:0]].
    - pix_on = in_win & ~busy & (bit ^ (cursor_hit & blink_phase)).
    - pix_valid = de (delayed 2).
- Out-of-window or de=0 pixels give pix_on=0. An out-of-window read address is don't-care and must not index outside the buffer (clamp to 0).
- Blink:
  - Counter increments on frame_start.
  - When it reaches BLINK_FRAMES-1 together with frame_start, it wraps to 0 and blink_phase toggles.
  - cursor_en=0 suppresses inversion but the counter keeps running.
- Simultaneous events:
  - Write and read to the same cell: old data is rendered this cycle, new data from the next read.
  - frame_start during busy: still counts.
- Font rows 8-15 and unknown codes render 0 (ROM default). The renderer does not special-case them.

Test Plan:
- Reset release, no writes -> busy=1 for exactly 2400 cycles, then 0. Full 640x480 scan gives pix_on=0 everywhere while pix_valid tracks de.
- After clear, write 7'h41 ('A') at col0,row0. Scan y=0 x=0..7 -> pix_on 0,0,0,1,1,0,0,0 (0x18). y=4 -> 0,1,1,1,1,1,1,0 (0x7E). y=8..15 -> all 0.
- Latency: present x=3,y=0 with de=1, surrounding pixels de=0 -> pix_on=1 and pix_valid=1 exactly two edges later, 0 at the edges before and after.
- cursor_en=1 at col1,row0 (space), pulse frame_start 30 times -> blink_phase=1 and x=8..15, y=0..15 all render pix_on=1. After 30 more pulses they render 0.
- wr_en asserted with wr_char=7'h31 while busy=1 -> after the sweep the cell renders space. A write with wr_col=80 -> ignored, no cell changes.
- Assert reset at sweep cycle 1000 -> busy stays 1 and completes 2400 cycles after release. pix_on=0 throughout.

Source files
------------

// File: rtl/text_cell_renderer.sv
// Character-cell text renderer.
// Holds a COLS x ROWS buffer of 7-bit character codes, looks up glyph rows in
// an external combinational font ROM and serialises them into a 1-bit pixel
// stream. The pixel-in to pixel-out latency is fixed at two clock edges.
// A blinking inverse-video cursor is overlaid on the stream.
// After reset the whole buffer is swept to spaces before any rendering.
module text_cell_renderer #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int ORIGIN_X     = 0,
  parameter int ORIGIN_Y     = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       de,
  input  logic       frame_start,
  input  logic       wr_en,
  input  logic [6:0] wr_col,
  input  logic [4:0] wr_row,
  input  logic [6:0] wr_char,
  input  logic       cursor_en,
  input  logic [6:0] cursor_col,
  input  logic [4:0] cursor_row,
  output logic [6:0] font_char_code,
  output logic [3:0] font_row_addr,
  input  logic [7:0] font_row_data,
  output logic       pix_on,
  output logic       pix_valid,
  output logic       busy
);

  localparam int              CELLS      = COLS * ROWS;
  localparam int              AW         = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [AW-1:0]   LAST_A     = AW'(CELLS - 1);
  localparam logic [AW-1:0]   COLS_A     = AW'(COLS);
  localparam logic [10:0]     WIN_W      = 11'(COLS * 8);
  localparam logic [10:0]     WIN_H      = 11'(ROWS * 16);
  localparam logic [31:0]     COLS_U     = 32'(COLS);
  localparam logic [31:0]     ROWS_U     = 32'(ROWS);
  localparam int              BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [6:0]      SPACE      = 7'h20;

  // ---------------------------------------------------------------------
  // Window geometry and cell addressing for the incoming pixel
  // ---------------------------------------------------------------------
  // One extra bit on the subtraction: bit 10 set means the pixel lies left of
  // (or above) the window origin.
  logic [10:0]   lx_full;
  logic [10:0]   ly_full;
  logic          in_geom;
  logic [6:0]    cell_col;
  logic [5:0]    cell_row;
  logic [AW-1:0] rd_addr;
  logic          cursor_hit;

  assign lx_full  = {1'b0, pixel_x} - 11'(ORIGIN_X);
  assign ly_full  = {1'b0, pixel_y} - 11'(ORIGIN_Y);
  assign in_geom  = ~lx_full[10] & (lx_full < WIN_W) &
                    ~ly_full[10] & (ly_full < WIN_H);
  assign cell_col = lx_full[9:3];
  assign cell_row = ly_full[9:4];
  // Out-of-window pixels read cell 0 so the buffer is never indexed past its end.
  assign rd_addr  = in_geom ? (AW'(cell_row) * COLS_A + AW'(cell_col)) : '0;
  assign cursor_hit = cursor_en & (cell_col == cursor_col) &
                      (cell_row == {1'b0, cursor_row});

  // ---------------------------------------------------------------------
  // Clear sweep: walks every cell once after reset release
  // ---------------------------------------------------------------------
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          busy_q, busy_d;

  // Next-state for the sweep: stop after the last cell has been written.
  always_comb begin
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    if (busy_q) begin
      if (clr_cnt_q == LAST_A) begin
        busy_d = 1'b0;
      end else begin
        clr_cnt_d = clr_cnt_q + AW'(1);
      end
    end
  end

  // Sweep state registers; reset restarts the sweep from cell 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;

  // ---------------------------------------------------------------------
  // Buffer write port: the sweep owns the port while busy
  // ---------------------------------------------------------------------
  logic          wr_in_range;
  logic [AW-1:0] wr_addr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [6:0]    mem_wdata;

  assign wr_in_range = ({25'd0, wr_col} < COLS_U) & ({27'd0, wr_row} < ROWS_U);
  assign wr_addr     = AW'(wr_row) * COLS_A + AW'(wr_col);

  // Select between the clear sweep and host writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = SPACE;
    if (busy_q) begin
      mem_we = 1'b1;
    end else if (wr_en && wr_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr;
      mem_wdata = wr_char;
    end
  end

  // ---------------------------------------------------------------------
  // Blink timer: counts frames, toggles phase every BLINK_FRAMES frames
  // ---------------------------------------------------------------------
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  // Next-state for the blink timer; it runs regardless of cursor_en or busy.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 0: buffer read and pixel attribute capture
  // ---------------------------------------------------------------------
  logic [6:0] text_mem [CELLS];
  logic [6:0] char_p0_q;
  logic [2:0] subx_p0_q;
  logic [3:0] suby_p0_q;
  logic       vld_p0_q;
  logic       win_p0_q;
  logic       hit_p0_q;

  // Text buffer: synchronous write and read-first synchronous read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      text_mem[mem_waddr] <= mem_wdata;
    end
    char_p0_q <= text_mem[rd_addr];
  end

  // Stage 0 data: position of the pixel inside its cell.
  always_ff @(posedge clk) begin
    subx_p0_q <= lx_full[2:0];
    suby_p0_q <= ly_full[3:0];
  end

  // Stage 0 control flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0_q <= 1'b0;
      win_p0_q <= 1'b0;
      hit_p0_q <= 1'b0;
    end else begin
      vld_p0_q <= de;
      win_p0_q <= de & in_geom;
      hit_p0_q <= cursor_hit;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: drive the font ROM from registers
  // ---------------------------------------------------------------------
  logic [6:0] font_code_q;
  logic [3:0] font_row_q;
  logic [2:0] subx_p1_q;
  logic       vld_p1_q;
  logic       win_p1_q;
  logic       hit_p1_q;

  // Stage 1 data: bit select carried alongside the ROM lookup.
  always_ff @(posedge clk) begin
    subx_p1_q <= subx_p0_q;
  end

  // Stage 1 font address and control flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      font_code_q <= SPACE;
      font_row_q  <= '0;
      vld_p1_q    <= 1'b0;
      win_p1_q    <= 1'b0;
      hit_p1_q    <= 1'b0;
    end else begin
      font_code_q <= char_p0_q;
      font_row_q  <= suby_p0_q;
      vld_p1_q    <= vld_p0_q;
      win_p1_q    <= win_p0_q;
      hit_p1_q    <= hit_p0_q;
    end
  end

  assign font_char_code = font_code_q;
  assign font_row_addr  = font_row_q;

  // ---------------------------------------------------------------------
  // Stage 2: pick the glyph bit, apply cursor inversion and blanking
  // ---------------------------------------------------------------------
  logic glyph_bit;
  logic pix_on_q;
  logic pix_valid_q;

  // MSB of the glyph row is the leftmost pixel, so bit index is 7 - subx.
  assign glyph_bit = font_row_data[~subx_p1_q];

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_on_q    <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      pix_on_q    <= win_p1_q & ~busy_q & (glyph_bit ^ (hit_p1_q & blink_phase_q));
      pix_valid_q <= vld_p1_q;
    end
  end

  assign pix_on    = pix_on_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_text_cell_renderer.sv
// Bench for text_cell_renderer: random and directed pixel streams checked
// against a cell-level model of the text buffer, cursor and blink timer.
module tb_text_cell_renderer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int BLINK = 30;
  localparam int CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] px = '0;
  logic [9:0] py = '0;
  logic       de_r = 1'b0;
  logic       fs = 1'b0;
  logic       wen = 1'b0;
  logic [6:0] wcol = '0;
  logic [4:0] wrow = '0;
  logic [6:0] wchar = '0;
  logic       cen = 1'b0;
  logic [6:0] ccol = '0;
  logic [4:0] crow = '0;
  logic [6:0] fcc;
  logic [3:0] fra;
  logic [7:0] frd;
  logic       pon;
  logic       pval;
  logic       bsy;

  text_cell_renderer dut (
    .clk(clk), .reset(reset), .pixel_x(px), .pixel_y(py), .de(de_r),
    .frame_start(fs), .wr_en(wen), .wr_col(wcol), .wr_row(wrow),
    .wr_char(wchar), .cursor_en(cen), .cursor_col(ccol), .cursor_row(crow),
    .font_char_code(fcc), .font_row_addr(fra), .font_row_data(frd),
    .pix_on(pon), .pix_valid(pval), .busy(bsy)
  );

  always #5 clk = ~clk;

  // Font ROM stand-in: 'A' has a real glyph, rows 8-15 and unknown codes are 0,
  // other printable codes get a pattern that always has bit 0 set.
  function automatic logic [7:0] font_rom(input logic [6:0] c, input logic [3:0] r);
    if (r[3]) return 8'h00;
    if (c == 7'h41) begin
      case (r[2:0])
        3'd0: return 8'h18;
        3'd1: return 8'h3C;
        3'd2: return 8'h66;
        3'd3: return 8'h66;
        3'd4: return 8'h7E;
        3'd5: return 8'h66;
        3'd6: return 8'h66;
        default: return 8'h00;
      endcase
    end
    if (c < 7'h21 || c > 7'h7E) return 8'h00;
    return {c ^ {r[2:0], 4'h0}, 1'b1};
  endfunction

  assign frd = font_rom(fcc, fra);

  typedef struct packed {
    logic win;
    logic de;
    logic hit;
    logic known;
    logic gbit;
  } ent_t;

  ent_t       q[$];
  logic [6:0] mmem [CELLS];
  bit         mknown [CELLS];
  int         clr_m = 0;
  int         bcnt_m = 0;
  bit         busy_m = 1'b1;
  bit         phase_m = 1'b0;
  int         errors = 0;
  int         checks = 0;
  logic       last_on = 1'b0;
  logic       last_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: predict the presented pixel, advance the model, compare the
  // DUT output belonging to the pixel presented two clocks ago.
  task automatic step();
    ent_t       e, o;
    int         lx, ly, a;
    logic [7:0] g;
    bit         pb, pp;
    logic       exp_on;
    lx = int'(px);
    ly = int'(py);
    e = '0;
    e.de = de_r;
    e.win = de_r && lx < COLS * 8 && ly < ROWS * 16;
    e.known = 1'b1;
    if (e.win) begin
      a = (ly / 16) * COLS + lx / 8;
      e.hit = cen && (lx / 8 == int'(ccol)) && (ly / 16 == int'(crow));
      e.known = mknown[a];
      g = font_rom(mmem[a], 4'(ly % 16));
      e.gbit = g[7 - lx % 8];
    end
    q.push_back(e);
    pb = busy_m;
    pp = phase_m;
    @(posedge clk);
    if (pb) begin
      mmem[clr_m] = 7'h20;
      mknown[clr_m] = 1'b1;
      if (clr_m == CELLS - 1) busy_m = 1'b0;
      clr_m++;
    end else if (wen && int'(wcol) < COLS && int'(wrow) < ROWS) begin
      a = int'(wrow) * COLS + int'(wcol);
      mmem[a] = wchar;
      mknown[a] = 1'b1;
    end
    if (fs) begin
      if (bcnt_m == BLINK - 1) begin
        bcnt_m = 0;
        phase_m = !phase_m;
      end else begin
        bcnt_m++;
      end
    end
    #1;
    o = q.pop_front();
    exp_on = o.win & ~pb & (o.gbit ^ (o.hit & pp));
    chk("pix_valid", 32'(pval), 32'(o.de));
    if (!(o.win && !pb && !o.known)) chk("pix_on", 32'(pon), 32'(exp_on));
    chk("busy", 32'(bsy), 32'(busy_m));
    last_on = pon;
    last_valid = pval;
  endtask

  task automatic do_reset(input int ncyc);
    wen = 1'b0;
    fs = 1'b0;
    de_r = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_busy_async", 32'(bsy), 32'd1);
    chk("rst_pix_on_async", 32'(pon), 32'd0);
    for (int i = 0; i < ncyc; i++) @(posedge clk);
    #1;
    chk("rst_pix_on", 32'(pon), 32'd0);
    chk("rst_pix_valid", 32'(pval), 32'd0);
    chk("rst_busy", 32'(bsy), 32'd1);
    chk("rst_font_code", 32'(fcc), 32'h20);
    chk("rst_font_row", 32'(fra), 32'd0);
    reset = 1'b0;
    q.delete();
    q.push_back('0);
    q.push_back('0);
    busy_m = 1'b1;
    clr_m = 0;
    bcnt_m = 0;
    phase_m = 1'b0;
  endtask

  task automatic rand_pixel();
    if ($urandom_range(0, 9) == 0) begin
      px = 10'($urandom_range(0, 1023));
      py = 10'($urandom_range(0, 1023));
    end else begin
      px = 10'($urandom_range(0, 127));
      py = 10'($urandom_range(0, 63));
    end
    de_r = ($urandom_range(0, 7) != 0);
  endtask

  // Scan eight pixels of one line and return what pix_on showed, MSB first.
  task automatic scan8(input int x0, input int y, output logic [7:0] b);
    b = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        px = 10'(x0 + i);
        py = 10'(y);
        de_r = 1'b1;
      end else begin
        de_r = 1'b0;
      end
      step();
      if (i >= 2) b[9 - i] = last_on;
    end
  endtask

  task automatic cell_ones(input int col, input int row, output int cnt);
    logic [7:0] b;
    cnt = 0;
    for (int y = 0; y < 16; y++) begin
      scan8(col * 8, row * 16 + y, b);
      cnt += $countones(b);
    end
  endtask

  task automatic write_cell(input int col, input int row, input logic [6:0] c);
    de_r = 1'b0;
    wen = 1'b1;
    wcol = 7'(col);
    wrow = 5'(row);
    wchar = c;
    step();
    wen = 1'b0;
  endtask

  task automatic pulse_frames(input int n);
    de_r = 1'b0;
    for (int i = 0; i < n; i++) begin
      fs = 1'b1;
      step();
      fs = 1'b0;
      step();
    end
  endtask

  initial begin
    int         n, ones, cnt;
    logic [7:0] b, acc;
    logic [3:0] s_on, s_val;

    #2;
    do_reset(3);

    // Clear sweep with write attempts that must be ignored.
    n = 0;
    while (bsy && n < 3000) begin
      rand_pixel();
      wen = 1'($urandom_range(0, 1));
      wcol = 7'd2;
      wrow = 5'd0;
      wchar = 7'h31;
      step();
      n++;
    end
    wen = 1'b0;
    chk("clear_cycles", 32'(n), 32'd2400);

    // Blank screen after the clear.
    ones = 0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 660; x++) begin
        px = 10'(x);
        py = 10'(y);
        de_r = (x < 640);
        step();
        ones += int'(last_on);
      end
    end
    for (int x = 0; x < 640; x++) begin
      px = 10'(x);
      py = 10'd479;
      de_r = 1'b1;
      step();
      ones += int'(last_on);
    end
    de_r = 1'b0;
    step();
    ones += int'(last_on);
    step();
    ones += int'(last_on);
    chk("blank_ones", 32'(ones), 32'd0);

    // 'A' in cell (0,0); out-of-range writes must not land anywhere.
    write_cell(0, 0, 7'h41);
    write_cell(80, 0, 7'h31);
    write_cell(0, 30, 7'h31);
    scan8(0, 0, b);
    chk("A_row0", 32'(b), 32'h18);
    scan8(0, 4, b);
    chk("A_row4", 32'(b), 32'h7E);
    acc = '0;
    for (int y = 8; y < 16; y++) begin
      scan8(0, y, b);
      acc |= b;
    end
    chk("A_rows8_15", 32'(acc), 32'h00);
    cell_ones(0, 1, cnt);
    chk("col80_ignored", 32'(cnt), 32'd0);

    // Latency: a single lit pixel surrounded by de=0.
    de_r = 1'b0;
    step();
    step();
    step();
    px = 10'd3;
    py = 10'd0;
    de_r = 1'b1;
    step();
    s_on[3] = last_on;
    s_val[3] = last_valid;
    de_r = 1'b0;
    step();
    s_on[2] = last_on;
    s_val[2] = last_valid;
    step();
    s_on[1] = last_on;
    s_val[1] = last_valid;
    step();
    s_on[0] = last_on;
    s_val[0] = last_valid;
    chk("latency_on", 32'(s_on), 32'b0010);
    chk("latency_valid", 32'(s_val), 32'b0010);

    // Cursor blink on the space in cell (1,0).
    cen = 1'b1;
    ccol = 7'd1;
    crow = 5'd0;
    pulse_frames(29);
    cell_ones(1, 0, cnt);
    chk("cursor_29_frames", 32'(cnt), 32'd0);
    pulse_frames(1);
    cell_ones(1, 0, cnt);
    chk("cursor_30_frames", 32'(cnt), 32'd128);
    pulse_frames(30);
    cell_ones(1, 0, cnt);
    chk("cursor_60_frames", 32'(cnt), 32'd0);
    cen = 1'b0;

    // Random traffic: writes often aimed at the cell being displayed.
    for (int i = 0; i < 20000; i++) begin
      rand_pixel();
      wen = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        wcol = 7'(px / 8);
        wrow = 5'(py / 16);
      end else begin
        wcol = 7'($urandom_range(0, 85));
        wrow = 5'($urandom_range(0, 31));
      end
      wchar = 7'($urandom_range(0, 127));
      fs = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) begin
        cen = 1'($urandom_range(0, 1));
        ccol = 7'($urandom_range(0, 15));
        crow = 5'($urandom_range(0, 3));
      end
      step();
    end
    wen = 1'b0;
    fs = 1'b0;
    cen = 1'b0;

    // Reset in the middle of a sweep restarts it.
    do_reset(2);
    ones = 0;
    for (int i = 0; i < 1000; i++) begin
      rand_pixel();
      wen = 1'($urandom_range(0, 1));
      wcol = 7'($urandom_range(0, 79));
      wrow = 5'($urandom_range(0, 29));
      wchar = 7'h31;
      step();
      ones += int'(last_on);
    end
    wen = 1'b0;
    do_reset(2);
    n = 0;
    while (bsy && n < 3000) begin
      rand_pixel();
      step();
      ones += int'(last_on);
      n++;
    end
    chk("restart_clear_cycles", 32'(n), 32'd2400);
    chk("restart_pix_on_ones", 32'(ones), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
